// File: rtl/mult_share_ctrl.sv
// Shares one combinational multiplier among NUM_REQ requesters: round-robin grant,
// multicycle operand hold, then product returned with requester ID on a valid/ready channel.

module multiplier #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0]   i_a,
    input  logic [SIZE-1:0]   i_b,
    output logic [2*SIZE-1:0] o_p
);
    assign o_p = {{SIZE{1'b0}}, i_a} * {{SIZE{1'b0}}, i_b};
endmodule

module mult_share_ctrl #(
    parameter int SIZE       = 4,
    parameter int NUM_REQ    = 4,
    parameter int ID_W       = 2,
    parameter int MUL_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*SIZE-1:0] req_x,
    input  logic [NUM_REQ*SIZE-1:0] req_y,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [2*SIZE-1:0]       resp_p,
    output logic                    busy
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

    state_t            r_state, w_next;
    logic [ID_W-1:0]   r_last_grant, r_id, r_resp_id, w_grant;
    logic [SIZE-1:0]   r_x, r_y, w_gx, w_gy;
    logic [3:0]        r_cnt;
    logic [2*SIZE-1:0] r_resp_p, w_prod;
    logic              r_resp_valid, w_any, w_hs;
    int                w_idx;

    // Search starts just past the last winner so every waiting requester gets a turn.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(r_last_grant) + k) % NUM_REQ;
            if (!w_any && req_valid[w_idx]) begin
                w_any   = 1'b1;
                w_grant = ID_W'(w_idx);
            end
        end
    end

    always_comb begin
        w_gx = '0;
        w_gy = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_gx = req_x[i*SIZE +: SIZE];
                w_gy = req_y[i*SIZE +: SIZE];
            end
        end
    end

    assign w_hs = (r_state == S_IDLE) && w_any && !reset;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_ready[i] = w_hs && (w_grant == ID_W'(i));
    end

    multiplier #(.SIZE(SIZE)) u_mul (
        .i_a (r_x),
        .i_b (r_y),
        .o_p (w_prod)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any)        w_next = S_CALC;
            S_CALC:  if (r_cnt == '0)  w_next = S_RESP;
            S_RESP:  if (resp_ready)   w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    // Operand regs only load in IDLE, so the multiplier inputs stay put for the whole settle window.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x          <= '0;
            r_y          <= '0;
            r_id         <= '0;
            r_cnt        <= '0;
            r_resp_p     <= '0;
            r_resp_id    <= '0;
            r_resp_valid <= 1'b0;
            r_last_grant <= ID_W'(NUM_REQ-1);
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_x          <= w_gx;
                        r_y          <= w_gy;
                        r_id         <= w_grant;
                        r_last_grant <= w_grant;
                        r_cnt        <= 4'(MUL_CYCLES-1);
                    end
                end
                S_CALC: begin
                    if (r_cnt == '0) begin
                        r_resp_p     <= w_prod;
                        r_resp_id    <= r_id;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) r_resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_p     = r_resp_p;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: one instance with MUL_CYCLES=1, one with MUL_CYCLES=3.

module tb_mult_share_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst3;
    logic [3:0]  rv, rv3, rdy, rdy3;
    logic [15:0] rx, ry, rx3, ry3;
    logic        rr, rr3, rvld, rvld3, bsy, bsy3;
    logic [1:0]  rid, rid3;
    logic [7:0]  rp, rp3;

    int n_tests = 0;
    int n_fail  = 0;

    mult_share_ctrl #(.SIZE(4), .NUM_REQ(4), .ID_W(2), .MUL_CYCLES(1)) u_dut (
        .clk(clk), .reset(rst), .req_valid(rv), .req_ready(rdy), .req_x(rx), .req_y(ry),
        .resp_valid(rvld), .resp_ready(rr), .resp_id(rid), .resp_p(rp), .busy(bsy));

    mult_share_ctrl #(.SIZE(4), .NUM_REQ(4), .ID_W(2), .MUL_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(rst3), .req_valid(rv3), .req_ready(rdy3), .req_x(rx3), .req_y(ry3),
        .resp_valid(rvld3), .resp_ready(rr3), .resp_id(rid3), .resp_p(rp3), .busy(bsy3));

    typedef struct {
        logic [1:0] id;
        logic [3:0] x;
        logic [3:0] y;
        logic [7:0] p;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out", nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // One isolated operation on the MUL_CYCLES=1 instance with exact latency checks.
    task automatic run_op(input logic [1:0] id, input logic [3:0] x, input logic [3:0] y,
                          input logic [7:0] p);
        step();
        rv = '0;
        rv[id] = 1'b1;
        rx[int'(id)*4 +: 4] = x;
        ry[int'(id)*4 +: 4] = y;
        rr = 1'b1;
        samp();
        chk("op_grant", 32'(rdy), 32'd1 << id);
        chk("op_busy_idle", 32'(bsy), 32'd0);
        step();
        rv = '0;
        samp();
        chk("op_calc_vld", 32'(rvld), 32'd0);
        chk("op_calc_busy", 32'(bsy), 32'd1);
        step();
        samp();
        chk("op_resp_vld", 32'(rvld), 32'd1);
        chk("op_resp_p", 32'(rp), 32'(p));
        chk("op_resp_id", 32'(rid), 32'(id));
        step();
        samp();
        chk("op_done_busy", 32'(bsy), 32'd0);
        chk("op_done_vld", 32'(rvld), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rr_ord[5];
        bit got;
        rr_ord = '{0, 1, 2, 3, 0};
        tbl[0] = '{id: 2'd2, x: 4'd13, y: 4'd11, p: 8'd143};
        tbl[1] = '{id: 2'd0, x: 4'd0,  y: 4'd9,  p: 8'd0};
        tbl[2] = '{id: 2'd1, x: 4'd15, y: 4'd1,  p: 8'd15};
        tbl[3] = '{id: 2'd3, x: 4'd15, y: 4'd15, p: 8'd225};
        tbl[4] = '{id: 2'd0, x: 4'd1,  y: 4'd15, p: 8'd15};
        tbl[5] = '{id: 2'd1, x: 4'd7,  y: 4'd8,  p: 8'd56};

        rst = 1'b1; rst3 = 1'b1;
        rv = 4'hF; rv3 = 4'hF;
        rx = '0; ry = '0; rx3 = '0; ry3 = '0;
        rr = 1'b0; rr3 = 1'b0;

        // Reset held two cycles with every requester asking.
        for (int c = 0; c < 2; c++) begin
            step();
            samp();
            chk("rst_ready", 32'(rdy), 32'd0);
            chk("rst_ready3", 32'(rdy3), 32'd0);
            chk("rst_vld", 32'(rvld), 32'd0);
            chk("rst_p", 32'(rp), 32'd0);
            chk("rst_id", 32'(rid), 32'd0);
            chk("rst_busy", 32'(bsy), 32'd0);
        end

        // Round-robin: all valid, operands x_i=i+12, y_i=15-i.
        step();
        rst = 1'b0; rst3 = 1'b0; rv3 = '0;
        for (int i = 0; i < 4; i++) begin
            rx[i*4 +: 4] = 4'(i + 12);
            ry[i*4 +: 4] = 4'(15 - i);
        end
        rr = 1'b1;
        samp();
        chk("rst_first_grant", 32'(rdy), 32'd1);
        for (int n = 0; n < 5; n++) begin
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                if (rdy != '0) got = 1'b1;
                else samp();
            end
            if (!got) timeout("rr_wait_grant");
            chk("rr_grant", 32'(rdy), 32'd1 << rr_ord[n]);
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                samp();
                if (rvld) got = 1'b1;
            end
            if (!got) timeout("rr_wait_resp");
            chk("rr_id", 32'(rid), 32'(rr_ord[n]));
            chk("rr_p", 32'(rp), 32'((rr_ord[n] + 12) * (15 - rr_ord[n])));
        end
        step();
        rv = '0;
        samp();
        chk("rr_idle", 32'(bsy), 32'd0);

        for (int t = 0; t < 6; t++)
            run_op(tbl[t].id, tbl[t].x, tbl[t].y, tbl[t].p);

        // Backpressure: 15*15 from requester 0, requester 1 waits meanwhile.
        step();
        rv = 4'b0001;
        rx[3:0] = 4'd15; ry[3:0] = 4'd15;
        rx[7:4] = 4'd2;  ry[7:4] = 4'd3;
        rr = 1'b0;
        samp();
        chk("bp_grant", 32'(rdy), 32'd1);
        step();
        rv = 4'b0010;
        samp();
        chk("bp_calc_ready", 32'(rdy), 32'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            samp();
            chk("bp_hold_vld", 32'(rvld), 32'd1);
            chk("bp_hold_p", 32'(rp), 32'd225);
            chk("bp_hold_id", 32'(rid), 32'd0);
            chk("bp_hold_ready", 32'(rdy), 32'd0);
        end
        step();
        rr = 1'b1;
        samp();
        chk("bp_release_vld", 32'(rvld), 32'd1);
        step();
        samp();
        chk("bp_after_vld", 32'(rvld), 32'd0);
        chk("bp_next_grant", 32'(rdy), 32'd2);
        step();
        rv = '0;
        samp();
        step();
        samp();
        chk("bp_next_vld", 32'(rvld), 32'd1);
        chk("bp_next_p", 32'(rp), 32'd6);
        chk("bp_next_id", 32'(rid), 32'd1);
        step();
        samp();
        chk("bp_idle", 32'(bsy), 32'd0);

        // Reset during the second CALC cycle of a MUL_CYCLES=3 operation.
        step();
        rv3 = 4'b0001;
        rx3[3:0] = 4'd9; ry3[3:0] = 4'd7;
        rx3[7:4] = 4'd5; ry3[7:4] = 4'd6;
        rx3[15:12] = 4'd10; ry3[15:12] = 4'd11;
        rr3 = 1'b0;
        samp();
        chk("mid_grant", 32'(rdy3), 32'd1);
        step();
        rv3 = '0;
        samp();
        step();
        rst3 = 1'b1;
        samp();
        chk("mid_rst_ready", 32'(rdy3), 32'd0);
        chk("mid_rst_busy", 32'(bsy3), 32'd1);
        step();
        rst3 = 1'b0;
        samp();
        chk("mid_after_busy", 32'(bsy3), 32'd0);
        chk("mid_after_vld", 32'(rvld3), 32'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            samp();
            chk("mid_no_resp", 32'(rvld3), 32'd0);
        end
        step();
        rv3 = 4'b1010;
        rr3 = 1'b1;
        samp();
        chk("mid_post_grant1", 32'(rdy3), 32'd2);
        for (int c = 0; c < 3; c++) begin
            step();
            samp();
            chk("mid_calc_vld", 32'(rvld3), 32'd0);
        end
        step();
        samp();
        chk("mid_resp_vld", 32'(rvld3), 32'd1);
        chk("mid_resp_p", 32'(rp3), 32'd30);
        chk("mid_resp_id", 32'(rid3), 32'd1);
        step();
        samp();
        chk("mid_grant3_over1", 32'(rdy3), 32'd8);
        step();
        rv3 = '0;
        step();
        step();
        step();
        samp();
        chk("mid3_resp_vld", 32'(rvld3), 32'd1);
        chk("mid3_resp_p", 32'(rp3), 32'd110);
        chk("mid3_resp_id", 32'(rid3), 32'd3);

        // Exhaustive operand sweep with rotating requesters.
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                run_op(2'((x * 16 + y) % 4), 4'(x), 4'(y), 8'(x * y));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
